// File: rtl/result_display_if.sv
// Result-display handshake bundle: operand and flags in, busy/done and four
// active-low seven-segment digit bytes out.
interface result_display_if;
  logic [7:0] value;
  logic       addSubOverflow;
  logic [1:0] multDivOverflow;
  logic       load;
  logic       busy;
  logic       done;
  logic [7:0] HEX0;
  logic [7:0] HEX1;
  logic [7:0] HEX2;
  logic [7:0] HEX3;

  modport master (
    output value, addSubOverflow, multDivOverflow, load,
    input  busy, done, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  value, addSubOverflow, multDivOverflow, load,
    output busy, done, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/result_display.sv
// Serial double-dabble binary-to-BCD converter driving three digit displays plus sign.
// Define RESULT_DISPLAY_SIGNED_EN to treat value as two's complement with a minus on HEX3.
module result_display (
  input  logic            clk,
  input  logic            rst,
  result_display_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        as_q, as_d;
  logic [1:0]  md_q, md_d;
  logic [7:0]  hex0_q, hex0_d;
  logic [7:0]  hex1_q, hex1_d;
  logic [7:0]  hex2_q, hex2_d;
  logic [7:0]  magnitude;
  logic [11:0] bcd_adj;
  logic [19:0] work;
  logic [3:0]  dig_h, dig_t, dig_o;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] dabble(input logic [3:0] d);
    dabble = (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

`ifdef RESULT_DISPLAY_SIGNED_EN
  logic neg_q, neg_d;
  logic [7:0] hex3_q, hex3_d;
  assign magnitude = bus.value[7] ? (~bus.value + 8'd1) : bus.value;
`else
  assign magnitude = bus.value;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      as_q    <= 1'b0;
      md_q    <= '0;
      hex0_q  <= 8'hFF;
      hex1_q  <= 8'hFF;
      hex2_q  <= 8'hFF;
`ifdef RESULT_DISPLAY_SIGNED_EN
      neg_q   <= 1'b0;
      hex3_q  <= 8'hFF;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      as_q    <= as_d;
      md_q    <= md_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
`ifdef RESULT_DISPLAY_SIGNED_EN
      neg_q   <= neg_d;
      hex3_q  <= hex3_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load) state_d = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, one dabble-and-shift per SHIFT cycle, display encode.
  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    op_d   = op_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    as_d   = as_q;
    md_d   = md_q;
    hex0_d = hex0_q;
    hex1_d = hex1_q;
    hex2_d = hex2_q;
`ifdef RESULT_DISPLAY_SIGNED_EN
    neg_d  = neg_q;
    hex3_d = hex3_q;
`endif

    bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};
    work    = {bcd_adj, op_q} << 1;
    dig_h   = work[19:16];
    dig_t   = work[15:12];
    dig_o   = work[11:8];

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          op_d  = magnitude;
          bcd_d = '0;
          cnt_d = '0;
          as_d  = bus.addSubOverflow;
          md_d  = bus.multDivOverflow;
`ifdef RESULT_DISPLAY_SIGNED_EN
          neg_d = bus.value[7];
`endif
        end
      end
      SHIFT: begin
        bcd_d = work[19:8];
        op_d  = work[7:0];
        if (cnt_q != 3'd7) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          // Last shift: the display is loaded so it is valid throughout UPDATE.
          hex0_d = {~md_q[0], seg7(dig_o)};
          hex1_d = {~md_q[1], (dig_h == 4'd0 && dig_t == 4'd0) ? 7'h7F : seg7(dig_t)};
          hex2_d = {~as_q, (dig_h == 4'd0) ? 7'h7F : seg7(dig_h)};
`ifdef RESULT_DISPLAY_SIGNED_EN
          hex3_d = neg_q ? 8'hBF : 8'hFF;
`endif
        end
      end
      default: ;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == UPDATE);
  end

  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX2 = hex2_q;
`ifdef RESULT_DISPLAY_SIGNED_EN
  assign bus.HEX3 = hex3_q;
`else
  assign bus.HEX3 = 8'hFF;
`endif

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed table, multi-cycle corner
// sequences and randomized conversions against a decimal-arithmetic model.
module tb_result_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_display_if bus ();

  result_display dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    logic [7:0]  value;
    logic        as;
    logic [1:0]  md;
    logic [31:0] exp_hex;   // {HEX3, HEX2, HEX1, HEX0}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hex_now();
    return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  // Reference: decimal digits via plain division, then blanking and dp rules.
  function automatic logic [31:0] model(input logic [7:0] v, input logic as, input logic [1:0] md);
    int mag;
    int h, t, o;
    logic neg;
    logic [7:0] h0, h1, h2, h3;
    mag = int'(v);
    neg = 1'b0;
`ifdef RESULT_DISPLAY_SIGNED_EN
    if (v[7]) begin
      neg = 1'b1;
      mag = 256 - int'(v);
    end
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    h0 = seg_tab[o];
    h1 = (h == 0 && t == 0) ? 8'hFF : seg_tab[t];
    h2 = (h == 0) ? 8'hFF : seg_tab[h];
    h3 = neg ? 8'hBF : 8'hFF;
    if (md[0]) h0 = h0 & 8'h7F;
    if (md[1]) h1 = h1 & 8'h7F;
    if (as)    h2 = h2 & 8'h7F;
    return {h3, h2, h1, h0};
  endfunction

  // One conversion: pulse load, scramble live inputs, wait (bounded) for done.
  task automatic do_conv(input logic [7:0] v, input logic as, input logic [1:0] md,
                         input logic [31:0] hold_exp,
                         output logic [31:0] hex, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    hex  = '1;
    @(negedge clk);
    bus.value           = v;
    bus.addSubOverflow  = as;
    bus.multDivOverflow = md;
    bus.load            = 1'b1;
    @(negedge clk);
    bus.load            = 1'b0;
    bus.value           = 8'($urandom);
    bus.addSubOverflow  = 1'($urandom);
    bus.multDivOverflow = 2'($urandom);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 4) check("hold_between_updates", hex_now(), hold_exp);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k;
        hex = hex_now();
      end
    end
    @(negedge clk);
    check("done_busy_after", {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  vec_t vecs [7];
  logic [31:0] prev;
  logic [31:0] hex;
  int lat, bcnt;

  initial begin
    vecs[0] = '{8'd0,   1'b0, 2'b00, 32'hFFFF_FFC0};
`ifdef RESULT_DISPLAY_SIGNED_EN
    vecs[1] = '{8'd255, 1'b0, 2'b00, 32'hBFFF_FFF9};
    vecs[4] = '{8'h80,  1'b0, 2'b00, 32'hBFF9_A480};
`else
    vecs[1] = '{8'd255, 1'b0, 2'b00, 32'hFFA4_9292};
    vecs[4] = '{8'h80,  1'b0, 2'b00, 32'hFFF9_A480};
`endif
    vecs[2] = '{8'd7,   1'b1, 2'b10, 32'hFF7F_7FF8};
    vecs[3] = '{8'd42,  1'b0, 2'b00, 32'hFFFF_99A4};
    vecs[5] = '{8'd100, 1'b0, 2'b01, 32'hFFF9_C040};
    vecs[6] = '{8'd9,   1'b0, 2'b00, 32'hFFFF_FF90};

    rst                 = 1'b1;
    bus.load            = 1'b0;
    bus.value           = '0;
    bus.addSubOverflow  = 1'b0;
    bus.multDivOverflow = '0;
    repeat (2) @(negedge clk);
    check("reset_hex", hex_now(), 32'hFFFF_FFFF);
    check("reset_busy_done", {30'd0, bus.done, bus.busy}, 32'd0);
    rst = 1'b0;

    // Directed table.
    prev = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      do_conv(vecs[i].value, vecs[i].as, vecs[i].md, prev, hex, lat, bcnt);
      check($sformatf("tbl%0d_latency", i), lat, 9);
      check($sformatf("tbl%0d_busy_cycles", i), bcnt, 9);
      check($sformatf("tbl%0d_hex", i), hex, vecs[i].exp_hex);
      prev = vecs[i].exp_hex;
    end

    // Loads while busy (mid-conversion and in the done cycle) are ignored.
    @(negedge clk);
    bus.value           = 8'd42;
    bus.addSubOverflow  = 1'b0;
    bus.multDivOverflow = 2'b00;
    bus.load            = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 9) begin
        check("busy_load_done", {31'd0, bus.done}, 32'd1);
        check("busy_load_hex", hex_now(), 32'hFFFF_99A4);
      end
      if (k == 10) check("busy_load_idle", {30'd0, bus.done, bus.busy}, 32'd0);
      if (k == 12) check("busy_load_hold", hex_now(), 32'hFFFF_99A4);
      bus.load            = (k == 3 || k == 9);
      bus.value           = 8'd99;
      bus.addSubOverflow  = 1'b1;
      bus.multDivOverflow = 2'b11;
    end
    bus.load = 1'b0;

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clk);
    bus.value = 8'd200;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_reset_hex", hex_now(), 32'hFFFF_FFFF);
    check("abort_reset_busy", {30'd0, bus.done, bus.busy}, 32'd0);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check("abort_no_activity", seen, 0);
    end
    check("abort_hex_blank", hex_now(), 32'hFFFF_FFFF);
    do_conv(8'd5, 1'b0, 2'b00, 32'hFFFF_FFFF, hex, lat, bcnt);
    check("after_abort_latency", lat, 9);
    check("after_abort_hex", hex, 32'hFFFF_FF92);
    prev = 32'hFFFF_FF92;

    // Randomized conversions against the decimal model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  v;
      logic        as;
      logic [1:0]  md;
      logic [31:0] exp_hex;
      v  = 8'($urandom);
      as = 1'($urandom);
      md = 2'($urandom);
      exp_hex = model(v, as, md);
      do_conv(v, as, md, prev, hex, lat, bcnt);
      check($sformatf("rnd%0d_latency", i), lat, 9);
      check($sformatf("rnd%0d_busy_cycles", i), bcnt, 9);
      check($sformatf("rnd%0d_hex_v%0d", i, v), hex, exp_hex);
      prev = exp_hex;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
